interrupt_ctrl: RTL
===================

Name: interrupt_ctrl

Overview:
- Parametrised successor to the single-flag IOT-600x interrupt handler.
- Decodes IOT 6000–6007 and owns the ION state machine, including the one-instruction ION/RTF enable delay.
- Collects NREQ device request lines through a mask, and hands the CPU a one-cycle interrupt-take pulse with a priority-encoded source ID at the instruction boundary.
- Sits beside the IOT decoder. Drives the same rotator/AC/link control strobes as the other IOT modules.

Parameters:
- NREQ, 8, number of device interrupt request lines (1..16).
- WORD, 12, AC/bus width.
- IDW, $clog2(NREQ) (min 1), width of int_id.

Ports:
- CLK  in  1  system clock.
- clear  in  1  synchronous reset, active-low.
- EN  in  1  high while an IOT for this device code executes.
- IR  in  3  IOT function bits.
- ck1  in  1  phase-1 clock enable from the sequencer.
- ck2  in  1  phase-2 clock enable from the sequencer.
- stb1  in  1  phase-1 strobe, single cycle.
- instr_end  in  1  one-cycle pulse at each instruction boundary (fetch point).
- ac_in  in  WORD  current AC, used by RTF.
- link_in  in  1  current link, used by GTF.
- gt_in  in  1  EAE GT flag, used by SGT and GTF.
- irq_req  in  NREQ  level-sensitive device requests.
- mask_we  in  1  single-cycle mask write.
- mask_in  in  NREQ  new mask value (1 = enabled).
- done  out  1  IOT complete.
- skip  out  1  skip next instruction; valid while EN.
- rot2ac  out  1  route rotator to AC.
- ac_ck  out  1  AC load.
- clr  out  1  clear rotator input.
- linkclr  out  1  clear link input.
- link_ck  out  1  link load.
- bus_out  out  WORD  GTF flags word.
- bus_oe  out  1  bus_out valid.
- link_out  out  1  link value for RTF restore.
- int_take  out  1  one-cycle interrupt grant.
- int_id  out  IDW  index of the granted source, held until the next take.
- ion  out  1  1 when the state machine is in ON.

Behaviour:
- Reset (clear low at a CLK edge):
  - state = OFF, mask = all ones, int_id = 0.
  - All outputs 0.
  - Reset overrides every other event in the same cycle, including mid-IOT and mid-take.
- Instruction decode: inst* = EN & (IR == n).
- State-changing effects happen only on EN & stb1, exactly once per IOT. EN level alone changes no state.
- done = EN & ck2.
- State machine:
  - States: OFF, ARM, DEFER, ON.
  - ION at stb1: OFF → ARM. Already in ARM/DEFER/ON: no change.
  - ARM → DEFER on instr_end, which is the end of the ION instruction itself.
  - DEFER → ON on the next instr_end. No take is permitted on that same edge.
  - IOF, CAF, or SKON-while-ON at stb1: any state → OFF.
- RTF at stb1:
  - ac_in[7] = 1 → ARM; ac_in[7] = 0 → OFF.
  - link_out = ac_in[11].
  - Asserts link_ck at stb1. linkclr stays 0.
- pending = |(irq_req & mask).
- Interrupt take:
  - Condition: state == ON & instr_end & pending & !(EN & stb1).
  - Actions: int_take = 1 for that cycle; state → OFF on the next edge; int_id latched as the lowest set index of (irq_req & mask). Index 0 has highest priority.
  - take and mask_we in the same cycle: the take uses the old mask.
- skip (combinational, gated by EN):
  - SKON: state == ON.
  - SRQ: pending.
  - SGT: gt_in.
  - All other functions: 0.
- SKON evaluates skip from the pre-clear state.
- GTF: bus_oe = EN & ck1, with bus_out bit layout:
  - [11] = link_in
  - [10] = gt_in
  - [9] = pending
  - [7] = (state == ON)
  - all other bits 0.
- CAF:
  - rot2ac = clr = linkclr = EN & ck1.
  - ac_k = link_ck = EN & stb1, which zeroes L and AC.
  - mask → all ones.
- mask_we loads mask_in on the next edge. An IOT in the same cycle does not block it.
- Widths: the priority encoder ignores bits above NREQ-1. int_id is zero-extended.

Decomposition:
- Shared package holds:
  - IOT function constants: IOT_SKON..IOT_CAF = 0..7.
  - ion_state_t enum: OFF, ARM, DEFER, ON.
  - GTF bit-position constants.
- One sub-module, prio_enc: parametrised lowest-index-first encoder with NREQ inputs, outputs IDW-wide index plus valid.

Test Plan:
- Reset: hold clear low 2 cycles with irq_req = 8'hFF → ion = 0, int_take = 0, mask = 8'hFF, all strobes 0.
- ION delay: ION, then instr_end, then one NOP with irq_req[3] = 1.
  - No int_take at the NOP's instr_end.
  - int_take = 1 with int_id = 3 at the following instr_end.
  - ion = 0 the next cycle.
- Priority/mask: ON, irq_req = 8'b0110_0100, mask_in = 8'b1111_1011 written → take yields int_id = 5. SRQ skip = 1.
- SKON: in ON → skip = 1 and ion = 0 after stb1. Repeat in OFF → skip = 0.
- GTF/RTF: link_in = 1, gt_in = 1, ON → bus_out = 12'o6200 (pending = 0).
  - RTF with ac_in = 12'o4200 → link_out = 1, link_ck pulses, state ARM.
  - ion = 1 after two instr_end pulses.
- CAF plus reset mid-IOT:
  - CAF → rot2ac/clr/linkclr at ck1, ac_ck/link_ck at stb1, ion = 0.
  - clear low in the same cycle as ION stb1 → state OFF.

Source files
------------

// File: rtl/interrupt_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
//   - IOT function codes (IR field values for device codes 6000-6007)
//   - ion_state_t: ION enable state machine states
//   - Bit positions of the GTF flags word and of the RTF restore word
package interrupt_ctrl_pkg;

  // IOT function codes, decoded from IR while EN is high
  localparam logic [2:0] IOT_SKON = 3'd0;
  localparam logic [2:0] IOT_ION  = 3'd1;
  localparam logic [2:0] IOT_IOF  = 3'd2;
  localparam logic [2:0] IOT_SRQ  = 3'd3;
  localparam logic [2:0] IOT_GTF  = 3'd4;
  localparam logic [2:0] IOT_RTF  = 3'd5;
  localparam logic [2:0] IOT_SGT  = 3'd6;
  localparam logic [2:0] IOT_CAF  = 3'd7;

  // ARM and DEFER together give the one-instruction enable delay after ION/RTF
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARM   = 2'd1,
    DEFER = 2'd2,
    ON    = 2'd3
  } ion_state_t;

  // GTF flags word layout
  localparam int GTF_LINK_BIT = 11;
  localparam int GTF_GT_BIT   = 10;
  localparam int GTF_PEND_BIT = 9;
  localparam int GTF_ION_BIT  = 7;

  // RTF takes the saved link and ION enable back from these AC bits
  localparam int RTF_LINK_BIT = 11;
  localparam int RTF_ION_BIT  = 7;

endpackage

// File: rtl/interrupt_ctrl_prio_enc.sv
// Lowest-index-first priority encoder.
//   req_i : NREQ request bits (bit 0 has highest priority)
//   id_o  : index of the lowest set bit, 0 when none set
//   vld_o : 1 when any request bit is set
module interrupt_ctrl_prio_enc #(
  parameter int NREQ = 8,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  output logic [IDW-1:0]  id_o,
  output logic            vld_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    id_o  = '0;
    vld_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o  = IDW'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt controller for IOT 6000-6007.
// Owns the ION state machine (OFF/ARM/DEFER/ON with the one-instruction enable
// delay after ION and RTF), masks NREQ level-sensitive device requests, and
// grants a one-cycle int_take with a priority-encoded int_id at an instruction
// boundary. Drives the shared rotator/AC/link strobes for CAF and RTF and the
// GTF flags word.
// Ports:
//   CLK, clear          clock, synchronous active-low reset
//   EN, IR              IOT select and function bits
//   ck1, ck2, stb1      sequencer phase enables / strobe
//   instr_end           instruction boundary pulse
//   ac_in, link_in      AC and link (RTF restore, GTF)
//   gt_in               EAE GT flag (SGT, GTF)
//   irq_req             device requests
//   mask_we, mask_in    request mask write
//   done, skip          IOT complete, skip next instruction
//   rot2ac, ac_ck, clr, linkclr, link_ck   AC/link control strobes
//   bus_out, bus_oe     GTF flags word
//   link_out            link value restored by RTF
//   int_take, int_id    interrupt grant and granted source
//   ion                 state machine is ON
module interrupt_ctrl
  import interrupt_ctrl_pkg::*;
#(
  parameter int NREQ = 8,
  parameter int WORD = 12,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            CLK,
  input  logic            clear,
  input  logic            EN,
  input  logic [2:0]      IR,
  input  logic            ck1,
  input  logic            ck2,
  input  logic            stb1,
  input  logic            instr_end,
  input  logic [WORD-1:0] ac_in,
  input  logic            link_in,
  input  logic            gt_in,
  input  logic [NREQ-1:0] irq_req,
  input  logic            mask_we,
  input  logic [NREQ-1:0] mask_in,
  output logic            done,
  output logic            skip,
  output logic            rot2ac,
  output logic            ac_ck,
  output logic            clr,
  output logic            linkclr,
  output logic            link_ck,
  output logic [WORD-1:0] bus_out,
  output logic            bus_oe,
  output logic            link_out,
  output logic            int_take,
  output logic [IDW-1:0]  int_id,
  output logic            ion
);

  ion_state_t      state_q, state_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [IDW-1:0]  int_id_q, int_id_d;

  logic            iot_stb;
  logic            inst_skon, inst_srq, inst_gtf, inst_rtf, inst_sgt, inst_caf;
  logic [NREQ-1:0] masked_req;
  logic            pending;
  logic [IDW-1:0]  enc_id;
  logic            enc_vld;
  logic            take;

  // Only bits 11 and 7 of the AC matter here
  logic            unused_ac;
  assign unused_ac = ^ac_in;

  assign iot_stb   = EN & stb1;
  assign inst_skon = EN & (IR == IOT_SKON);
  assign inst_srq  = EN & (IR == IOT_SRQ);
  assign inst_gtf  = EN & (IR == IOT_GTF);
  assign inst_rtf  = EN & (IR == IOT_RTF);
  assign inst_sgt  = EN & (IR == IOT_SGT);
  assign inst_caf  = EN & (IR == IOT_CAF);

  // Uses the registered mask, so a mask write in the take cycle is not seen yet
  assign masked_req = irq_req & mask_q;
  assign pending    = |masked_req;

  interrupt_ctrl_prio_enc #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_prio_enc (
    .req_i (masked_req),
    .id_o  (enc_id),
    .vld_o (enc_vld)
  );

  // An IOT strobe in the boundary cycle suppresses the take
  assign take = (state_q == ON) & instr_end & enc_vld & ~iot_stb;

  // State register
  always_ff @(posedge CLK) begin
    if (!clear) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: boundary progression first, then any IOT at stb1 overrides it
  always_comb begin
    state_d = state_q;
    if (take) begin
      state_d = OFF;
    end else if (instr_end) begin
      case (state_q)
        ARM:     state_d = DEFER;
        DEFER:   state_d = ON;
        default: state_d = state_q;
      endcase
    end
    if (iot_stb) begin
      case (IR)
        IOT_ION:  if (state_q == OFF) state_d = ARM;
        IOT_IOF:  state_d = OFF;
        IOT_CAF:  state_d = OFF;
        IOT_SKON: if (state_q == ON) state_d = OFF;
        IOT_RTF:  state_d = ac_in[RTF_ION_BIT] ? ARM : OFF;
        default:  ;
      endcase
    end
  end

  // Outputs; everything is held at 0 while clear is asserted
  always_comb begin
    done     = 1'b0;
    skip     = 1'b0;
    rot2ac   = 1'b0;
    ac_ck    = 1'b0;
    clr      = 1'b0;
    linkclr  = 1'b0;
    link_ck  = 1'b0;
    bus_out  = '0;
    bus_oe   = 1'b0;
    link_out = 1'b0;
    int_take = 1'b0;
    int_id   = '0;
    ion      = 1'b0;
    if (clear) begin
      done     = EN & ck2;
      // SKON sees the state before its own stb1 turns interrupts off
      skip     = (inst_skon & (state_q == ON)) | (inst_srq & pending) | (inst_sgt & gt_in);
      bus_oe   = inst_gtf & ck1;
      if (bus_oe) begin
        bus_out[GTF_LINK_BIT] = link_in;
        bus_out[GTF_GT_BIT]   = gt_in;
        bus_out[GTF_PEND_BIT] = pending;
        bus_out[GTF_ION_BIT]  = (state_q == ON);
      end
      // CAF loads zero into AC and link through the cleared rotator path
      rot2ac   = inst_caf & ck1;
      clr      = inst_caf & ck1;
      linkclr  = inst_caf & ck1;
      ac_ck    = inst_caf & stb1;
      link_ck  = (inst_caf | inst_rtf) & stb1;
      link_out = inst_rtf & ac_in[RTF_LINK_BIT];
      int_take = take;
      int_id   = int_id_q;
      ion      = (state_q == ON);
    end
  end

  // Mask and granted-source registers
  always_comb begin
    mask_d = mask_q;
    if (iot_stb & inst_caf) mask_d = '1;
    if (mask_we)            mask_d = mask_in;
    int_id_d = take ? enc_id : int_id_q;
  end

  always_ff @(posedge CLK) begin
    if (!clear) begin
      mask_q   <= '1;
      int_id_q <= '0;
    end else begin
      mask_q   <= mask_d;
      int_id_q <= int_id_d;
    end
  end

endmodule
